// File: rtl/counter_share_arb.sv
// Round-robin arbiter that lends one shared up/down counter to two requesters.
// Optional PAUSE_EN macro adds a pause_i input that freezes a running job.
module counter_share_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             req0_i,
  input  logic             dir0_i,
  input  logic [WIDTH-1:0] target0_i,
  input  logic             req1_i,
  input  logic             dir1_i,
  input  logic [WIDTH-1:0] target1_i,
`ifdef PAUSE_EN
  input  logic             pause_i,
`endif
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic             done0_o,
  output logic             done1_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] count_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             busy_q, busy_d;
  logic             owner_req;
  logic             pause_act;
  logic             step_en;

`ifdef PAUSE_EN
  assign pause_act = pause_i;
`else
  assign pause_act = 1'b0;
`endif

  assign owner_req = owner_q ? req1_i : req0_i;

  // last_q resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      dir_q   <= 1'b0;
      tgt_q   <= '0;
      count_q <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      tgt_q   <= tgt_d;
      count_q <= count_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    step_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req0_i || req1_i) begin
          owner_d = (req0_i && req1_i) ? ~last_q : req1_i;
          dir_d   = owner_d ? dir1_i : dir0_i;
          tgt_d   = owner_d ? target1_i : target0_i;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!owner_req) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end else if (!pause_act) begin
          if (count_q == tgt_q) begin
            state_d = ST_DONE;
            last_d  = owner_q;
          end else begin
            step_en = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are computed from next state so they land in registers.
  always_comb begin
    count_d = count_q;
    if (step_en) begin
      count_d = dir_q ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
    end
    busy_d  = (state_d != ST_IDLE);
    gnt0_d  = busy_d && !owner_d;
    gnt1_d  = busy_d && owner_d;
    done0_d = (state_d == ST_DONE) && !owner_d;
    done1_d = (state_d == ST_DONE) && owner_d;
  end

  assign gnt0_o  = gnt0_q;
  assign gnt1_o  = gnt1_q;
  assign done0_o = done0_q;
  assign done1_o = done1_q;
  assign busy_o  = busy_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_counter_share_arb.sv
// Directed self-checking bench for counter_share_arb; define PAUSE_EN to cover pause_i.
module tb_counter_share_arb;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req0, dir0, req1, dir1;
  logic [7:0] target0, target1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [7:0] count;
`ifdef PAUSE_EN
  logic       pause = 1'b0;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  counter_share_arb #(.WIDTH(8)) dut (
    .clk_i(clk), .reset_ni(reset_n),
    .req0_i(req0), .dir0_i(dir0), .target0_i(target0),
    .req1_i(req1), .dir1_i(dir1), .target1_i(target1),
`ifdef PAUSE_EN
    .pause_i(pause),
`endif
    .gnt0_o(gnt0), .gnt1_o(gnt1), .done0_o(done0), .done1_o(done1),
    .busy_o(busy), .count_o(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic [7:0] exp_cnt, input logic eg0,
                           input logic eg1, input logic ed0, input logic ed1, input logic eb);
    tests_run++;
    if ({count, gnt0, gnt1, done0, done1, busy} !== {exp_cnt, eg0, eg1, ed0, ed1, eb}) begin
      tests_failed++;
      $display("FAIL %s: got count=%02h g0=%b g1=%b d0=%b d1=%b busy=%b, want count=%02h g0=%b g1=%b d0=%b d1=%b busy=%b",
               name, count, gnt0, gnt1, done0, done1, busy, exp_cnt, eg0, eg1, ed0, ed1, eb);
    end else begin
      $display("[TB] ok %s count=%02h", name, count);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    req0 = 0; req1 = 0; dir0 = 0; dir1 = 0; target0 = 0; target1 = 0;
    reset_n = 1'b0;
    #2;
    chk_state("reset_async", 8'h00, 0, 0, 0, 0, 0);
    tick();
    chk_state("reset_held", 8'h00, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    tick();
    chk_state("reset_idle", 8'h00, 0, 0, 0, 0, 0);
  endtask

  task automatic test_single_up();
    req0 = 1; dir0 = 1; target0 = 8'd5;
    tick();
    chk_state("up_grant", 8'd0, 1, 0, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_state($sformatf("up_step%0d", k), 8'(k), 1, 0, 0, 0, 1);
    end
    tick();
    chk_state("up_done", 8'd5, 1, 0, 1, 0, 1);
    req0 = 0;
    tick();
    chk_state("up_idle", 8'd5, 0, 0, 0, 0, 0);
    tick();
    chk_state("up_hold", 8'd5, 0, 0, 0, 0, 0);
  endtask

  task automatic test_down_wrap();
    logic [7:0] exp_seq [4] = '{8'h01, 8'h00, 8'hFF, 8'hFE};
    // Bring count from 5 down to 2 first.
    req0 = 1; dir0 = 0; target0 = 8'd2;
    tick();
    for (int k = 0; k < 3; k++) tick();
    tick();
    chk_state("pre_down_done", 8'd2, 1, 0, 1, 0, 1);
    req0 = 0;
    tick();
    req1 = 1; dir1 = 0; target1 = 8'hFE;
    tick();
    chk_state("wrap_grant", 8'd2, 0, 1, 0, 0, 1);
    dir1 = 1; target1 = 8'h00;  // must be ignored while running
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_state($sformatf("wrap_step%0d", k), exp_seq[k], 0, 1, 0, 0, 1);
    end
    tick();
    chk_state("wrap_done", 8'hFE, 0, 1, 0, 1, 1);
    tick();
    chk_state("wrap_idle", 8'hFE, 0, 0, 0, 0, 0);
    req1 = 0;
  endtask

  task automatic test_tie_rr();
    reset_n = 1'b0;
    req0 = 1; dir0 = 1; target0 = 8'd3;
    req1 = 1; dir1 = 1; target1 = 8'd6;
    tick();
    reset_n = 1'b1;
    tick();
    chk_state("tie_grant0", 8'd0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) tick();
    tick();
    chk_state("tie_done0", 8'd3, 1, 0, 1, 0, 1);
    req0 = 0;
    tick();
    chk_state("tie_idle", 8'd3, 0, 0, 0, 0, 0);
    tick();
    chk_state("rr_grant1", 8'd3, 0, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) tick();
    tick();
    chk_state("rr_done1", 8'd6, 0, 1, 0, 1, 1);
    req0 = 1; target0 = 8'd6;
    tick();
    tick();
    chk_state("rr_regrant0", 8'd6, 1, 0, 0, 0, 1);
    tick();
    chk_state("zero_dist_done0", 8'd6, 1, 0, 1, 0, 1);
    req0 = 0;
    tick();
    tick();
    chk_state("rr_grant1_again", 8'd6, 0, 1, 0, 0, 1);
    tick();
    chk_state("zero_dist_done1", 8'd6, 0, 1, 0, 1, 1);
    req1 = 0;
    tick();
  endtask

  task automatic test_abort();
    req0 = 1; dir0 = 1; target0 = 8'd20;
    tick();
    for (int k = 0; k < 3; k++) tick();
    chk_state("abort_pre", 8'd9, 1, 0, 0, 0, 1);
    req0 = 0;
    tick();
    chk_state("abort_idle", 8'd9, 0, 0, 0, 0, 0);
    tick();
    chk_state("abort_no_done", 8'd9, 0, 0, 0, 0, 0);
    // Abort marked requester 0 as last served, so requester 1 wins the tie.
    req0 = 1; req1 = 1; dir1 = 0; target1 = 8'd9;
    tick();
    chk_state("abort_rr_gnt1", 8'd9, 0, 1, 0, 0, 1);
    tick();
    chk_state("abort_rr_done1", 8'd9, 0, 1, 0, 1, 1);
    req0 = 0; req1 = 0;
    tick();
  endtask

  task automatic test_reset_midrun();
    do_reset();
    req0 = 1; dir0 = 1; target0 = 8'h50;
    tick();
    for (int k = 0; k < 8'h37; k++) tick();
    chk_state("midrun_pre", 8'h37, 1, 0, 0, 0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_state("midrun_async_clear", 8'h00, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk_state("midrun_held", 8'h00, 0, 0, 0, 0, 0);
    req0 = 0;
    reset_n = 1'b1;
    tick();
  endtask

`ifdef PAUSE_EN
  task automatic test_pause();
    do_reset();
    req0 = 1; dir0 = 1; target0 = 8'd4;
    tick();
    tick();
    tick();
    chk_state("pause_pre", 8'd2, 1, 0, 0, 0, 1);
    pause = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_state($sformatf("pause_hold%0d", k), 8'd2, 1, 0, 0, 0, 1);
    end
    pause = 0;
    tick();
    tick();
    chk_state("pause_resume", 8'd4, 1, 0, 0, 0, 1);
    tick();
    chk_state("pause_done", 8'd4, 1, 0, 1, 0, 1);
    req0 = 0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_up();
    test_down_wrap();
    test_tie_rr();
    test_abort();
    test_reset_midrun();
`ifdef PAUSE_EN
    test_pause();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/counter_share_arb.md
Name: counter_share_arb

Overview:
Controller and arbiter that shares one internal up/down counter between two requesters. Each requester submits a run job: a direction and a target value. The arbiter grants one job at a time using round-robin, steps the counter once per clock until it equals the target, then pulses that requester's done. The block sits between the lab's stimulus/control logic and the counter datapath, and it owns the counter register.

Parameters:
WIDTH, 8, width of counter and target values; all arithmetic is modulo 2^WIDTH

Ports:
clk  in  1  system clock, rising-edge active
reset  in  1  asynchronous reset, active-low; the block is held in reset while low
req0  in  1  requester 0 job request; level, held high until done0 or abort
dir0  in  1  requester 0 direction; 1 = up, 0 = down
target0  in  WIDTH  requester 0 stop value
req1  in  1  requester 1 job request
dir1  in  1  requester 1 direction
target1  in  WIDTH  requester 1 stop value
gnt0  out  1  requester 0 owns the counter
gnt1  out  1  requester 1 owns the counter
done0  out  1  one-cycle pulse: requester 0 job complete
done1  out  1  one-cycle pulse: requester 1 job complete
busy  out  1  high in RUN or DONE
count  out  WIDTH  current counter value

Behaviour:
- Reset (asynchronous, reset low): count=0, state=IDLE, gnt0=gnt1=0, done0=done1=0, busy=0, last_served=1 so that requester 0 wins the first tie. All registers clear immediately, including mid-job. No done is issued for a job cut off by reset.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - No req: stay in IDLE; count holds.
  - Exactly one req: grant that requester.
  - Both reqs: grant the requester other than last_served.
  - On the granting edge: latch the winner's target and dir into job registers, set gnt_i, go to RUN. count does not step on this edge.
- RUN, one evaluation per rising edge:
  - Granted req_i low: abort. Go to IDLE, clear gnt_i, no done pulse, count holds, last_served=i.
  - Else count==latched target: go to DONE, count holds.
  - Else step count by +1 (dir=1) or -1 (dir=0), modulo 2^WIDTH. Up from 255 gives 0; down from 0 gives 255.
- DONE: done_i=1 for exactly this one cycle, gnt_i stays high, last_served=i. Next edge: go to IDLE, clear gnt_i and done_i.
- Latency, for a job with step distance N (counted in the latched direction, modulo 256):
  - Grant edge at cycle 0.
  - N stepping edges, then the DONE edge at cycle N+1.
  - done_i visible during cycle N+1; next grant possible at edge N+3 (after the IDLE edge at N+2).
  - Target equal to count at grant (N=0): done at cycle 1.
- Changes to target_i or dir_i during RUN or DONE are ignored; the job registers hold the latched values.
- A non-granted request waits. It is served no later than after the current job ends (round-robin fairness).
- count is never reset between jobs; each job starts from the previous final value.
- busy = (state != IDLE). gnt0 and gnt1 are never high together.
- Outputs are defined for all inputs; no x is propagated.

Optional Feature:
PAUSE_EN
- Defined: adds input port pause (1 bit). While pause=1 in RUN, count and state hold: no step, no DONE transition. An abort via req low still takes effect during pause. pause has no effect in IDLE or DONE.
- Not defined: no pause port; RUN steps every cycle as above.

Test Plan:
- Reset sequence: drive reset low mid-RUN at count=0x37 -> count=0x00, gnt0=gnt1=0, busy=0 immediately, without waiting for a clock edge.
- Single up job: count=0, req0=1, dir0=1, target0=5 -> gnt0 at edge 0, count 1..5 on edges 1..5, done0 pulse in cycle 6, count stays 5.
- Down wrap: count=2, req1=1, dir1=0, target1=0xFE -> count 1,0,0xFF,0xFE, then a single done1 pulse (4 steps).
- Tie and round-robin: both req high from reset, targets 3 and 6, up -> requester 0 served first (count to 3). Requester 1 granted on the first IDLE edge after done0, counts to 6. Re-raising req0 with req1 still high -> requester 0 wins the next grant.
- Zero-distance and abort: target equal to count -> done at cycle 1. In a separate job, drop req0 mid-RUN at count=9 -> IDLE, no done0, count=9.
- PAUSE_EN build: pause=1 for 3 cycles mid-RUN -> count frozen for those 3 cycles, done arrives 3 cycles later than the unpaused timing.
